// File: rtl/square_seq_if.sv
// Start/ready handshake bundle for square_seq: operand in, accumulator and
// result-valid out. Shared shape with the sequential square-root block.
interface square_seq_if #(
   parameter int unsigned N = 8
);
   logic           start;
   logic [N/2-1:0] A;
   logic [N-1:0]   O;
   logic           ready;

   modport master (
      output start,
      output A,
      input  O,
      input  ready
   );

   modport slave (
      input  start,
      input  A,
      output O,
      output ready
   );
endinterface

// File: rtl/square_seq.sv
// Sequential unsigned squarer O = A*A by shift-and-add, one operand bit per cycle.
// Define SQUARE_SEQ_RADIX4_EN to retire two bits per cycle (N must be a multiple of 4).
module square_seq #(
   parameter int unsigned N = 8,
   parameter int unsigned M = N / 2
) (
   input logic          clk,
   input logic          rst,
   square_seq_if.slave  bus
);

   localparam int unsigned CW = (M > 1) ? $clog2(M) : 1;

`ifdef SQUARE_SEQ_RADIX4_EN
   localparam logic [CW-1:0] LastCount = CW'(M / 2 - 1);
`else
   localparam logic [CW-1:0] LastCount = CW'(M - 1);
`endif

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StDone
   } state_t;

   state_t        state_q, state_d;
   logic [M-1:0]  a_q, a_d;
   logic [N-1:0]  acc_q, acc_d;
   logic [CW-1:0] count_q, count_d;
   logic          ready_q, ready_d;

   logic [N-1:0]  a_ext;
   logic [N-1:0]  addend;

   assign a_ext = {{(N - M){1'b0}}, a_q};

`ifdef SQUARE_SEQ_RADIX4_EN
   logic [CW:0]  digit_shift;
   logic [1:0]   digit;
   logic [N-1:0] multiple;

   // Digit multiple is one of 0, a, 2a, 3a; 3a never overflows N bits.
   always_comb begin
      digit_shift = {count_q, 1'b0};
      digit       = 2'(a_q >> digit_shift);
      multiple    = '0;
      case (digit)
         2'd1:    multiple = a_ext;
         2'd2:    multiple = a_ext << 1;
         2'd3:    multiple = (a_ext << 1) + a_ext;
         default: multiple = '0;
      endcase
      addend = multiple << digit_shift;
   end
`else
   always_comb begin
      addend = '0;
      if (a_q[count_q]) begin
         addend = a_ext << count_q;
      end
   end
`endif

   // start wins over iteration in every state, including BUSY and DONE.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      acc_d   = acc_q;
      count_d = count_q;
      ready_d = ready_q;

      if (bus.start) begin
         a_d     = bus.A;
         acc_d   = '0;
         count_d = '0;
         ready_d = 1'b0;
         state_d = StBusy;
      end else begin
         case (state_q)
            StBusy: begin
               acc_d   = acc_q + addend;
               count_d = count_q + 1'b1;
               if (count_q == LastCount) begin
                  state_d = StDone;
                  ready_d = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         a_q     <= '0;
         acc_q   <= '0;
         count_q <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         acc_q   <= acc_d;
         count_q <= count_d;
         ready_q <= ready_d;
      end
   end

   assign bus.O     = acc_q;
   assign bus.ready = ready_q;

endmodule

// File: tb/tb_square_seq.sv
// Self-checking bench for square_seq: directed handshake scenarios plus random
// operands against a cycle-count reference model (honours SQUARE_SEQ_RADIX4_EN).
module tb_square_seq;

   localparam int unsigned N = 8;
   localparam int unsigned M = N / 2;
`ifdef SQUARE_SEQ_RADIX4_EN
   localparam int Lat = M / 2;
`else
   localparam int Lat = M;
`endif

   logic clk;
   logic rst;

   square_seq_if #(.N(N)) bus ();

   square_seq #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: edges since the last start edge (-1 = nothing started since reset).
   int           mdl_cyc = -1;
   logic [M-1:0] mdl_a   = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic compare();
      longint sq;
      sq = longint'(mdl_a) * longint'(mdl_a);
      check("ready", 64'(bus.ready), 64'(mdl_cyc == Lat));
      if (mdl_cyc == -1 || mdl_cyc == 0) check("o_zero", 64'(bus.O), 64'd0);
      else if (mdl_cyc == Lat) check("o_square", 64'(bus.O), 64'(sq));
   endtask

   // Advance one rising edge with the inputs currently driven, then check.
   task automatic tick();
      if (bus.start) begin
         mdl_cyc = 0;
         mdl_a   = bus.A;
      end else if (mdl_cyc >= 0 && mdl_cyc < Lat) begin
         mdl_cyc++;
      end
      @(posedge clk);
      #1;
      compare();
   endtask

   task automatic launch(input logic [M-1:0] a, input int hold);
      bus.start = 1'b1;
      bus.A     = a;
      for (int i = 0; i < hold; i++) tick();
      bus.start = 1'b0;
      bus.A     = M'($urandom);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.A     = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      compare();
      rst = 1'b0;
      idle(2);

      // Single computation, then results must hold while idle.
      launch(M'(15), 1);
      idle(Lat + 10);

      // Back-to-back: each new start lands on the first ready cycle.
      launch(M'(0), 1);
      idle(Lat);
      launch(M'(1), 1);
      idle(Lat);
      launch(M'(8), 1);
      idle(Lat);

      // Abort mid-busy with a new operand.
      launch(M'(15), 1);
      idle(2);
      launch(M'(3), 1);
      idle(Lat + 2);

      // Start held high keeps reloading.
      launch(M'(12), 3);
      idle(Lat + 2);

      // Asynchronous reset between edges mid-busy.
      launch(M'(13), 1);
      idle(1);
      #2 rst = 1'b1;
      #1;
      mdl_cyc = -1;
      compare();
      #1 rst = 1'b0;
      idle(Lat + 3);
      launch(M'(13), 1);
      idle(Lat + 1);

      // Exhaustive operands, back to back.
      for (int a = 0; a < (1 << M); a++) begin
         launch(M'(a), 1);
         idle(Lat);
      end

      // Random operands with random hold and occasional abort.
      for (int k = 0; k < 60; k++) begin
         launch(M'($urandom), int'($urandom_range(3, 1)));
         idle(int'($urandom_range(Lat + 2, 0)));
      end
      idle(Lat + 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
